sub3_stream_ctrl: RTL and testbench

Stream controller that sits directly upstream of the masked 3-bit subtractor gadget and feeds it. It accepts masked operand pairs over a valid/ready handshake, registers them onto the subtractor inputs, and tracks each issued pair through the subtractor's fixed, non-stallable pipeline. It captures the masked 4-bit signed differences into an output FIFO and uses credit-based issue, so no result is ever dropped. Shares are only moved and stored, never recombined.

---
 rtl/sub3_stream_if.sv | 23 ++
 rtl/sub3_stream_ctrl.sv | 60 ++++++
 tb/tb_sub3_stream_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sub3_stream_if.sv
// sub3_stream_if: operand/result handshake and subtractor bundle for sub3_stream_ctrl
interface sub3_stream_if #(parameter int D = 2, parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH + 1);
  logic in_valid;
  logic in_ready;
  logic [3*D-1:0] in_a;
  logic [3*D-1:0] in_b;
  logic [3*D-1:0] sub_a;
  logic [3*D-1:0] sub_b;
  logic [4*D-1:0] sub_c;
  logic out_valid;
  logic out_ready;
  logic [4*D-1:0] out_c;
  logic [CW-1:0] pending;
  modport slave(
    input in_valid, in_a, in_b, sub_c, out_ready,
    output in_ready, sub_a, sub_b, out_valid, out_c, pending
  );
  modport master(
    output in_valid, in_a, in_b, sub_c, out_ready,
    input in_ready, sub_a, sub_b, out_valid, out_c, pending
  );
endinterface

// File: rtl/sub3_stream_ctrl.sv
// sub3_stream_ctrl: credit-based feeder for the masked 3-bit subtractor with a result FIFO
module sub3_stream_ctrl #(
  parameter int D = 2,
  parameter int LAT = 6,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  sub3_stream_if.slave s
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [CW-1:0] r_cnt;
  logic [LAT-1:0] r_vp;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [3*D-1:0] r_a;
  logic [3*D-1:0] r_b;
  logic [4*D-1:0] r_mem [DEPTH];
  logic w_issue;
  logic w_pop;
  logic w_capture;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  assign s.in_ready = r_cnt < CW'(DEPTH);
  assign s.out_valid = r_wr_ptr != r_rd_ptr;
  assign w_issue = s.in_valid && s.in_ready;
  assign w_pop = s.out_valid && s.out_ready;
  assign w_capture = r_vp[LAT-1];
  assign w_wr_idx = DEPTH == 1 ? '0 : r_wr_ptr[AW-1:0];
  assign w_rd_idx = DEPTH == 1 ? '0 : r_rd_ptr[AW-1:0];
  assign s.sub_a = r_a;
  assign s.sub_b = r_b;
  assign s.out_c = r_mem[w_rd_idx];
  assign s.pending = r_cnt;
  // credits cover in-flight plus stored results, so a capture always finds room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_vp <= '0;
      r_cnt <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_issue) begin
        r_a <= s.in_a;
        r_b <= s.in_b;
      end
      r_vp <= LAT'({r_vp, w_issue});
      r_cnt <= r_cnt + CW'(w_issue) - CW'(w_pop);
      if (w_capture) begin
        r_mem[w_wr_idx] <= s.sub_c;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_sub3_stream_ctrl.sv
// tb_sub3_stream_ctrl: scoreboard bench with a behavioural masked subtractor model
module tb_sub3_stream_ctrl;
  localparam int D = 2;
  localparam int LAT = 6;
  localparam int DEPTH = 8;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int fails = 0;
  int ready_drops = 0;
  logic [3:0] exp_q[$];
  logic [4*D-1:0] sc [LAT-1];
  sub3_stream_if #(.D(D), .DEPTH(DEPTH)) bus();
  sub3_stream_ctrl #(.D(D), .LAT(LAT), .DEPTH(DEPTH)) dut(.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  function automatic logic [4*D-1:0] mask(input logic [3:0] v);
    logic [4*D-1:0] m;
    logic x;
    for (int i = 0; i < 4; i++) begin
      x = v[i];
      for (int j = 1; j < D; j++) begin
        m[D*i+j] = 1'($urandom);
        x = x ^ m[D*i+j];
      end
      m[D*i] = x;
    end
    return m;
  endfunction
  function automatic logic [3:0] unm(input logic [4*D-1:0] m);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0;
      for (int j = 0; j < D; j++) v[i] = v[i] ^ m[D*i+j];
    end
    return v;
  endfunction
  // subtractor stand-in: LAT-1 stages after the operand register, fresh masks each result
  always @(posedge clk) begin
    sc[0] <= mask(unm({{D{1'b0}}, bus.sub_a}) - unm({{D{1'b0}}, bus.sub_b}));
    for (int i = 1; i < LAT - 1; i++) sc[i] <= sc[i-1];
  end
  assign bus.sub_c = sc[LAT-2];
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL extra_result got=%h required=none", unm(bus.out_c));
      end else if (unm(bus.out_c) !== exp_q[0]) begin
        fails++;
        $display("FAIL result got=%h required=%h", unm(bus.out_c), exp_q[0]);
        void'(exp_q.pop_front());
      end else void'(exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic send(input logic [2:0] a, input logic [2:0] b);
    int n = 0;
    bus.in_valid = 1;
    bus.in_a = mask({1'b0, a})[3*D-1:0];
    bus.in_b = mask({1'b0, b})[3*D-1:0];
    if (!bus.in_ready) ready_drops++;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout got=in_ready_low required=in_ready_high");
    end else exp_q.push_back(4'({1'b0, a} - {1'b0, b}));
    tick();
    bus.in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_pending", bus.pending, 0);
  endtask
  initial begin
    int n;
    bus.in_valid = 0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 0;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_sub_a", bus.sub_a, 0);
    chk("rst_sub_b", bus.sub_b, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_c", bus.out_c, 0);
    chk("rst_pending", bus.pending, 0);
    rst = 0;
    tick();
    bus.out_ready = 1;
    send(3'd5, 3'd3);
    chk("single_pending", bus.pending, 1);
    chk("single_sub_a", unm({{D{1'b0}}, bus.sub_a}), 5);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("single_latency", n, LAT);
    chk("single_pending_held", bus.pending, 1);
    tick();
    chk("single_pop_pending", bus.pending, 0);
    chk("single_one_pulse", bus.out_valid, 0);
    send(3'd1, 3'd6);
    send(3'd0, 3'd7);
    repeat (LAT) tick();
    chk("neg_consec_valid", bus.out_valid, 1);
    drain();
    bus.out_ready = 0;
    for (int i = 0; i < DEPTH; i++) send(3'(i), 3'(7 - i));
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_pending", bus.pending, DEPTH);
    bus.out_ready = 1;
    chk("bp_ready_before_pop", bus.in_ready, 0);
    tick();
    chk("bp_ready_after_pop", bus.in_ready, 1);
    send(3'd6, 3'd2);
    send(3'd2, 3'd5);
    drain();
    ready_drops = 0;
    for (int i = 0; i < 100; i++) send(3'($urandom), 3'($urandom));
    chk("stream_ready_drops", ready_drops, 0);
    drain();
    bus.out_ready = 0;
    for (int i = 0; i < DEPTH - 1; i++) send(3'(7 - i), 3'(i));
    repeat (LAT + 1) tick();
    chk("pp_pending_before", bus.pending, DEPTH - 1);
    bus.out_ready = 1;
    bus.in_valid = 1;
    bus.in_a = mask(4'd4)[3*D-1:0];
    bus.in_b = mask(4'd1)[3*D-1:0];
    chk("pp_in_ready", bus.in_ready, 1);
    exp_q.push_back(4'd3);
    tick();
    bus.in_valid = 0;
    chk("pp_pending_after", bus.pending, DEPTH - 1);
    drain();
    bus.out_ready = 0;
    for (int i = 0; i < 4; i++) send(3'(i + 3), 3'(i));
    repeat (3) tick();
    #2 rst = 1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_pending", bus.pending, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    tick();
    rst = 0;
    bus.out_ready = 1;
    repeat (2 * LAT) tick();
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_pending", bus.pending, 0);
    send(3'd7, 3'd0);
    drain();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end
endmodule
